// File: rtl/regfile_dump_if.sv
// regfile_dump_if: output beat stream of the register-file dump engine.
//   valid/ready : beat handshake; a transfer is coincident valid && ready
//   addr        : register address of the beat
//   data        : register value of the beat
//   last        : beat is for the final address of the range
// master drives the beat (the dump engine), slave consumes it.
interface regfile_dump_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          valid;
  logic          ready;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;
  logic          last;

  modport master (output valid, addr, data, last, input ready);
  modport slave  (input valid, addr, data, last, output ready);
endinterface

// File: rtl/regfile_dump.sv
// regfile_dump: debug read-out engine for the CPU register file.
// On start it walks start_addr..end_addr (inclusive, wrapping through
// NREGS-1 -> 0) through a combinational read port and streams each
// (address, value) pair over a valid/ready handshake. Never writes.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   start               : begin a dump (IDLE only)
//   start_addr/end_addr : range, sampled when start is accepted
//   abort               : synchronous cancel, highest priority
//   rf_ra / rf_rd       : register file read address / combinational data
//   ob                  : beat stream (valid/ready/addr/data/last)
//   busy                : not IDLE
//   done                : one-cycle pulse after the last beat is accepted
module regfile_dump #(
  parameter int NREGS = 32,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [AW-1:0]        start_addr,
  input  logic [AW-1:0]        end_addr,
  input  logic                 abort,
  output logic [AW-1:0]        rf_ra,
  input  logic [DW-1:0]        rf_rd,
  regfile_dump_if.master       ob,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {IDLE, FETCH, SEND, FIN} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cur_q;
  logic [AW-1:0] end_q;
  logic [AW-1:0] nxt_addr;

  // control strobes from the next-state logic
  logic do_load;   // accept start: latch range
  logic do_cap;    // end of FETCH: capture rf_rd into the beat
  logic do_adv;    // beat accepted, more to go: step the address
  logic do_acc;    // beat accepted: drop valid
  logic do_kill;   // abort: drop the beat

  assign nxt_addr = (cur_q == AW'(NREGS - 1)) ? '0 : cur_q + AW'(1);

  // rf_ra follows the current address in every state, so it simply
  // holds its last value while IDLE.
  assign rf_ra = cur_q;
  assign busy  = (state_q != IDLE);
  assign done  = (state_q == FIN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    do_load = 1'b0;
    do_cap  = 1'b0;
    do_adv  = 1'b0;
    do_acc  = 1'b0;
    do_kill = 1'b0;
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      do_kill = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          // abort in the same cycle suppresses the start
          if (start && !abort) begin
            do_load = 1'b1;
            state_d = FETCH;
          end
        end
        FETCH: begin
          do_cap  = 1'b1;
          state_d = SEND;
        end
        SEND: begin
          // valid is always high in SEND, so ready alone marks a transfer
          if (ob.ready) begin
            do_acc = 1'b1;
            if (ob.last) begin
              state_d = FIN;
            end else begin
              do_adv  = 1'b1;
              state_d = FETCH;
            end
          end
        end
        FIN:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_q    <= '0;
      end_q    <= '0;
      ob.valid <= 1'b0;
      ob.addr  <= '0;
      ob.data  <= '0;
      ob.last  <= 1'b0;
    end else begin
      if (do_load) begin
        cur_q <= start_addr;
        end_q <= end_addr;
      end
      if (do_adv) cur_q <= nxt_addr;
      if (do_cap) begin
        ob.data  <= rf_rd;
        ob.addr  <= cur_q;
        ob.last  <= (cur_q == end_q);
        ob.valid <= 1'b1;
      end
      if (do_acc) ob.valid <= 1'b0;
      if (do_kill) begin
        ob.valid <= 1'b0;
        ob.last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_dump.sv
// tb_regfile_dump: directed self-checking bench for regfile_dump.
module tb_regfile_dump;
  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          abort;
  logic [AW-1:0] start_addr;
  logic [AW-1:0] end_addr;
  logic [AW-1:0] rf_ra;
  logic [DW-1:0] rf_rd;
  logic          busy;
  logic          done;

  regfile_dump_if #(.AW(AW), .DW(DW)) ob ();

  regfile_dump #(.NREGS(NREGS), .AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .start_addr (start_addr),
    .end_addr   (end_addr),
    .abort      (abort),
    .rf_ra      (rf_ra),
    .rf_rd      (rf_rd),
    .ob         (ob),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] rf_mem [NREGS];
  assign rf_rd = rf_mem[rf_ra];

  int n_checks = 0;
  int n_fail   = 0;

  // results of the last run_dump
  logic [AW-1:0] cap_addr [$];
  logic [DW-1:0] cap_data [$];
  logic          cap_last [$];
  int done_cnt, done_cyc, idle_cyc, stall_cnt, hold_bad;
  bit timed_out;

  // Drives one dump and records every transfer. Cycle 0 is the cycle
  // after the edge that samples start. ready: random if rnd, else high
  // from cycle 'stall' on. A second start (10..10) pulses at mid_cyc.
  task automatic run_dump(input int sa, input int ea, input int stall,
                          input bit rnd, input int mid_cyc, input int max_cyc);
    int cyc;
    bit h_valid;
    logic [AW-1:0] h_addr;
    logic [DW-1:0] h_data;
    logic h_last;
    cap_addr.delete(); cap_data.delete(); cap_last.delete();
    done_cnt = 0; done_cyc = -1; idle_cyc = -1; stall_cnt = 0; hold_bad = 0;
    timed_out = 0; h_valid = 0; h_addr = '0; h_data = '0; h_last = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; start_addr = AW'(sa); end_addr = AW'(ea);
    ob.ready = rnd ? 1'($urandom_range(0, 1)) : (stall == 0);
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (1) begin
      @(negedge clk);
      if (ob.valid) begin
        if (h_valid && (ob.addr !== h_addr || ob.data !== h_data || ob.last !== h_last))
          hold_bad++;
        if (!ob.ready) stall_cnt++;
        h_valid = !ob.ready; h_addr = ob.addr; h_data = ob.data; h_last = ob.last;
        if (ob.ready) begin
          cap_addr.push_back(ob.addr);
          cap_data.push_back(ob.data);
          cap_last.push_back(ob.last);
        end
      end else begin
        h_valid = 0;
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (!busy) begin idle_cyc = cyc; break; end
      if (cyc >= max_cyc) begin timed_out = 1; break; end
      @(posedge clk);
      cyc++;
      #1;
      start = (cyc == mid_cyc);
      if (cyc == mid_cyc) begin start_addr = 10; end_addr = 10; end
      ob.ready = rnd ? 1'($urandom_range(0, 1)) : (cyc >= stall);
    end
    start = 1'b0;
    ob.ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0; start_addr = '0; end_addr = '0;
    ob.ready = 1'b0;
    #1;
    n_checks++;
    if ({ob.valid, ob.last, busy, done} !== 4'b0)
      $display("FAIL reset_flags: got %b want 0000", {ob.valid, ob.last, busy, done});
    n_checks++;
    if ({rf_ra, ob.addr, ob.data} !== '0)
      $display("FAIL reset_bus: got ra=%0h addr=%0h data=%0h want 0", rf_ra, ob.addr, ob.data);
    if ({ob.valid, ob.last, busy, done} !== 4'b0) n_fail++;
    if ({rf_ra, ob.addr, ob.data} !== '0) n_fail++;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || ob.valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got busy=%b valid=%b want 0 0", busy, ob.valid);
    end
  endtask

  task automatic test_full_range();
    run_dump(0, 31, 0, 0, -1, 200);
    n_checks++;
    if (cap_addr.size() != 32 || timed_out) begin
      n_fail++;
      $display("FAIL full_count: got %0d beats (timeout=%0d) want 32", cap_addr.size(), timed_out);
    end
    for (int k = 0; k < cap_addr.size(); k++) begin
      logic [DW-1:0] exp_d;
      exp_d = DW'(k) * 32'h0101_0101;
      n_checks++;
      if (cap_addr[k] !== AW'(k) || cap_data[k] !== exp_d || cap_last[k] !== (k == 31)) begin
        n_fail++;
        $display("FAIL full_beat%0d: got a=%0d d=%h l=%b want a=%0d d=%h l=%b",
                 k, cap_addr[k], cap_data[k], cap_last[k], k, exp_d, (k == 31));
      end
    end
    n_checks++;
    if (done_cnt != 1 || done_cyc != 64) begin
      n_fail++;
      $display("FAIL full_done: got cnt=%0d cyc=%0d want cnt=1 cyc=64", done_cnt, done_cyc);
    end
    n_checks++;
    if (idle_cyc != 65) begin
      n_fail++;
      $display("FAIL full_busy_low: got cyc=%0d want 65", idle_cyc);
    end
  endtask

  // wrapping range with a start pulse injected mid-dump (must be ignored)
  task automatic test_wrap_and_mid_start();
    logic [AW-1:0] exp_a [5];
    exp_a[0] = 30; exp_a[1] = 31; exp_a[2] = 0; exp_a[3] = 1; exp_a[4] = 2;
    run_dump(30, 2, 0, 0, 3, 100);
    n_checks++;
    if (cap_addr.size() != 5) begin
      n_fail++;
      $display("FAIL wrap_count: got %0d want 5", cap_addr.size());
    end
    for (int k = 0; k < cap_addr.size() && k < 5; k++) begin
      n_checks++;
      if (cap_addr[k] !== exp_a[k] || cap_data[k] !== DW'(exp_a[k]) * 32'h0101_0101 ||
          cap_last[k] !== (k == 4)) begin
        n_fail++;
        $display("FAIL wrap_beat%0d: got a=%0d d=%h l=%b want a=%0d l=%b",
                 k, cap_addr[k], cap_data[k], cap_last[k], exp_a[k], (k == 4));
      end
    end
    n_checks++;
    if (done_cnt != 1 || done_cyc != 10) begin
      n_fail++;
      $display("FAIL wrap_done: got cnt=%0d cyc=%0d want 1 10", done_cnt, done_cyc);
    end
  endtask

  task automatic test_single_stall();
    run_dump(7, 7, 11, 0, -1, 100);
    n_checks++;
    if (cap_addr.size() != 1 || cap_addr[0] !== 7 || cap_data[0] !== 32'h0707_0707 ||
        cap_last[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL single_beat: got n=%0d a=%0d d=%h want n=1 a=7 d=07070707 l=1",
               cap_addr.size(), cap_addr[0], cap_data[0]);
    end
    n_checks++;
    if (stall_cnt != 10 || hold_bad != 0) begin
      n_fail++;
      $display("FAIL single_hold: got stalled=%0d unstable=%0d want 10 0", stall_cnt, hold_bad);
    end
    n_checks++;
    if (done_cnt != 1 || done_cyc != 12) begin
      n_fail++;
      $display("FAIL single_done: got cnt=%0d cyc=%0d want 1 12", done_cnt, done_cyc);
    end
  endtask

  task automatic test_backpressure();
    int bad;
    run_dump(0, 31, 0, 1, -1, 2000);
    n_checks++;
    if (cap_addr.size() != 32 || timed_out) begin
      n_fail++;
      $display("FAIL bp_count: got %0d (timeout=%0d) want 32", cap_addr.size(), timed_out);
    end
    bad = 0;
    for (int k = 0; k < cap_addr.size(); k++)
      if (cap_addr[k] !== AW'(k) || cap_data[k] !== DW'(k) * 32'h0101_0101 ||
          cap_last[k] !== (k == 31)) bad++;
    n_checks++;
    if (bad != 0 || hold_bad != 0) begin
      n_fail++;
      $display("FAIL bp_order: got %0d bad beats, %0d unstable want 0 0", bad, hold_bad);
    end
    n_checks++;
    if (done_cnt != 1) begin
      n_fail++;
      $display("FAIL bp_done: got %0d want 1", done_cnt);
    end
  endtask

  task automatic test_abort();
    bit found;
    int dn;
    @(posedge clk); #1;
    start = 1'b1; start_addr = 0; end_addr = 31; ob.ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    found = 0;
    // accept beats 0..4 one at a time, then stall on 5
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (ob.valid && ob.addr == 5) begin found = 1; break; end
      if (ob.valid) ob.ready = 1'b1;
      @(posedge clk); #1;
      ob.ready = 1'b0;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL abort_reach5: got no stall at addr 5 want stall");
    end
    @(negedge clk);
    n_checks++;
    if (ob.valid !== 1'b1 || ob.addr !== 5 || ob.data !== 32'h0505_0505) begin
      n_fail++;
      $display("FAIL abort_stalled: got v=%b a=%0d d=%h want 1 5 05050505", ob.valid, ob.addr, ob.data);
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({ob.valid, busy, ob.last, done} !== 4'b0) begin
      n_fail++;
      $display("FAIL abort_idle: got v/busy/last/done=%b want 0000", {ob.valid, busy, ob.last, done});
    end
    dn = 0;
    repeat (5) begin @(negedge clk); if (done) dn++; end
    n_checks++;
    if (dn != 0) begin
      n_fail++;
      $display("FAIL abort_nodone: got %0d done pulses want 0", dn);
    end
    // abort and start together in IDLE: start is dropped
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_start_same: got busy=%b want 0", busy);
    end
    run_dump(0, 0, 0, 0, -1, 100);
    n_checks++;
    if (cap_addr.size() != 1 || cap_addr[0] !== 0 || cap_data[0] !== 0 || cap_last[0] !== 1'b1 ||
        done_cyc != 2) begin
      n_fail++;
      $display("FAIL abort_restart: got n=%0d done_cyc=%0d want n=1 a=0 d=0 l=1 done_cyc=2",
               cap_addr.size(), done_cyc);
    end
  endtask

  task automatic test_async_reset();
    bit found;
    int stray;
    @(posedge clk); #1;
    start = 1'b1; start_addr = 0; end_addr = 31; ob.ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (ob.valid && ob.addr >= 3) begin found = 1; break; end
    end
    n_checks++;
    if (!found || ob.data === '0) begin
      n_fail++;
      $display("FAIL areset_setup: got found=%0d data=%h want beat >=3 with data", found, ob.data);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({ob.valid, ob.last, busy, done} !== 4'b0 || {rf_ra, ob.addr, ob.data} !== '0) begin
      n_fail++;
      $display("FAIL areset_async: got v/l/b/d=%b ra=%0h a=%0h d=%h want all 0",
               {ob.valid, ob.last, busy, done}, rf_ra, ob.addr, ob.data);
    end
    #1 reset = 1'b0;
    ob.ready = 1'b0;
    stray = 0;
    repeat (6) begin @(negedge clk); if (ob.valid || busy || done) stray++; end
    n_checks++;
    if (stray != 0) begin
      n_fail++;
      $display("FAIL areset_idle: got %0d active cycles want 0", stray);
    end
    run_dump(3, 4, 0, 0, -1, 100);
    n_checks++;
    if (cap_addr.size() != 2 || cap_addr[0] !== 3 || cap_addr[1] !== 4 ||
        cap_data[1] !== 32'h0404_0404 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL areset_after: got n=%0d done=%0d want n=2 a=3,4 done=1", cap_addr.size(), done_cnt);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NREGS; i++) rf_mem[i] = DW'(i) * 32'h0101_0101;
    test_reset();
    test_full_range();
    test_wrap_and_mid_start();
    test_single_stall();
    test_backpressure();
    test_abort();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
